sel_sequencer: RTL

SEL_SEQUENCER -- requirements
Module: sel_sequencer

---
 rtl/sel_pkg.sv | 16 +
 rtl/sel_sequencer_if.sv | 30 +++
 rtl/sel_prescaler.sv | 30 +++
 rtl/sel_sequencer.sv | 111 +++++++++++
 4 files changed

// File: rtl/sel_pkg.sv
// Shared encodings for the selector sequencer: sequence modes and step direction.
package sel_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_BOUNCE  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/sel_sequencer_if.sv
// Control and status bundle of the selector sequencer; dir mirrors the direction FSM for debug.
interface sel_sequencer_if
  import sel_pkg::*;
#(
  parameter int SEL_W = 6
);
  // No valid/ready handshake: en and mode are levels sampled every rising edge,
  // load is a single-cycle strobe that wins over a coincident tick, and step/wrap
  // are single-cycle pulses aligned with the first cycle of a new sel value.
  logic             en;
  mode_t            mode;
  logic             load;
  logic [SEL_W-1:0] load_val;
  logic [SEL_W-1:0] sel;
  logic             step;
  logic             wrap;
  logic             phase;
  logic             done;
  dir_t             dir;

  modport master (
    output en, mode, load, load_val,
    input  sel, step, wrap, phase, done, dir
  );

  modport slave (
    input  en, mode, load, load_val,
    output sel, step, wrap, phase, done, dir
  );
endinterface

// File: rtl/sel_prescaler.sv
// Dwell counter: counts 0..DWELL-1 while run is high and pulses tick on the wrapping edge.
module sel_prescaler #(
  parameter int DWELL = 101
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (run)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = run && !clr && (cnt_q == LAST);
endmodule

// File: rtl/sel_sequencer.sv
// Selector sequencer: steps sel every DWELL enabled cycles in WRAP, BOUNCE or ONESHOT order.
module sel_sequencer
  import sel_pkg::*;
#(
  parameter int SEL_W   = 6,
  parameter int SEL_MAX = 37,
  parameter int DWELL   = 101
) (
  input logic            clk,
  input logic            rst_n,
  sel_sequencer_if.slave bus
);
  localparam logic [SEL_W-1:0] MAX = SEL_W'(SEL_MAX);

  logic             tick;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             phase_q, phase_d;
  logic             done_q, done_d;
  dir_t             dir_q, dir_d;
  dir_t             eff_dir;
  logic [SEL_W-1:0] bnc_nxt;
  logic [SEL_W-1:0] sel_inc;

  sel_prescaler #(.DWELL(DWELL)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (bus.en && (bus.mode != MODE_HOLD)),
    .clr   (bus.load),
    .tick  (tick)
  );

  // The end stops override the retained direction, so entering BOUNCE at 0 or MAX turns correctly.
  assign eff_dir = (sel_q == MAX) ? DIR_DOWN : ((sel_q == '0) ? DIR_UP : dir_q);
  assign bnc_nxt = (eff_dir == DIR_UP) ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
  assign sel_inc = sel_q + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q   <= DIR_UP;
      sel_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    dir_d = dir_q;
    if (bus.load || bus.mode == MODE_WRAP || bus.mode == MODE_ONESHOT)
      dir_d = DIR_UP;
    else if (bus.mode == MODE_BOUNCE && tick)
      dir_d = (bnc_nxt == MAX) ? DIR_DOWN : ((bnc_nxt == '0) ? DIR_UP : eff_dir);
  end

  always_comb begin
    sel_d  = sel_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    done_d = done_q && (bus.mode == MODE_ONESHOT);
    if (bus.load) begin
      sel_d  = (bus.load_val > MAX) ? MAX : bus.load_val;
      done_d = 1'b0;
    end else if (tick) begin
      case (bus.mode)
        MODE_WRAP: begin
          step_d = 1'b1;
          if (sel_q >= MAX) begin
            sel_d  = '0;
            wrap_d = 1'b1;
          end else begin
            sel_d = sel_inc;
          end
        end
        MODE_BOUNCE: begin
          step_d = 1'b1;
          sel_d  = bnc_nxt;
          wrap_d = (bnc_nxt == MAX) || (bnc_nxt == '0);
        end
        MODE_ONESHOT: begin
          // Already parked at MAX on entry: finish without moving.
          if (!done_q && sel_q >= MAX) begin
            done_d = 1'b1;
          end else if (!done_q) begin
            sel_d  = sel_inc;
            step_d = 1'b1;
            done_d = (sel_inc == MAX);
          end
        end
        default: ;
      endcase
    end
    phase_d = phase_q ^ wrap_d;
  end

  assign bus.sel   = sel_q;
  assign bus.step  = step_q;
  assign bus.wrap  = wrap_q;
  assign bus.phase = phase_q;
  assign bus.done  = done_q;
  assign bus.dir   = dir_q;
endmodule
